wb_arbiter: RTL and testbench

Writeback arbiter between the execute/memory stages and the 32-entry register file write port. It merges two result sources into the single write port (Write_register / Write_data / RegWrite). The first source is the single-cycle ALU path, which has no backpressure. The second is the long-latency load/multiply-divide path, which uses a valid/ready handshake and is buffered in a small FIFO. Outputs are registered and drive the register file directly; the register file commits on the following falling edge.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_arbiter_if.sv | 40 ++++
 rtl/wb_fifo.sv | 44 ++++
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared writeback types: widths, source tag and the queued result entry.
// Used by the arbiter, its FIFO and the bus interface.
package wb_pkg;

    localparam int XLEN = 32;
    localparam int AREG = 5;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_SLOW
    } wb_src_e;

    typedef struct packed {
        logic [AREG-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the execute/memory stages, the arbiter and the regfile.
// master drives results in; slave is the arbiter side.
interface wb_arbiter_if #(
    parameter int DEPTH = 2
);
    import wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic            alu_valid;
    logic [AREG-1:0] alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            slow_valid;
    logic            slow_ready;
    logic [AREG-1:0] slow_rd;
    logic [XLEN-1:0] slow_data;
    logic            wb_we;
    logic [AREG-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            stall_req;
    logic [CW-1:0]   fifo_count;
    logic            err_sticky;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output slow_valid, slow_rd, slow_data,
        input  slow_ready,
        input  wb_we, wb_rd, wb_data,
        input  stall_req, fifo_count, err_sticky
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  slow_valid, slow_rd, slow_data,
        output slow_ready,
        output wb_we, wb_rd, wb_data,
        output stall_req, fifo_count, err_sticky
    );

endinterface

// File: rtl/wb_fifo.sv
// Slow-path result queue: DEPTH entries, pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  wb_entry_t              din,
    output wb_entry_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    wb_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH_C);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/wb_arbiter.sv
// Merges the ALU result and the queued slow-path results into the single
// register file write port, ALU first, with starvation-driven stall.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    wb_src_e         src;
    wb_entry_t       slow_entry;
    wb_entry_t       head;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic [CW-1:0]   cnt_nxt;
    logic            ready_q;
    logic            stall_q;
    logic            err_q;
    logic [SW-1:0]   starve;
    logic [SW-1:0]   starve_nxt;
    logic            we_q;
    logic [AREG-1:0] rd_q;
    logic [XLEN-1:0] data_q;

    assign slow_entry = '{rd: bus.slow_rd, data: bus.slow_data};

    // rd==0 results finish the handshake but never occupy a slot
    assign push = bus.slow_valid && bus.slow_ready && (bus.slow_rd != '0);

    always_comb begin
        src = WB_NONE;
        if (bus.alu_valid) src = WB_ALU;
        else if (!empty)   src = WB_SLOW;
    end

    assign pop     = (src == WB_SLOW);
    assign cnt_nxt = count + CW'(push) - CW'(pop);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (slow_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        starve_nxt = starve;
        if (pop || empty)
            starve_nxt = '0;
        else if (bus.alu_valid && starve != LIMIT_C)
            starve_nxt = starve + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b1;
            starve  <= '0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= (cnt_nxt < DEPTH_C);
            starve  <= starve_nxt;
            if (pop)
                stall_q <= 1'b0;
            else if (starve_nxt == LIMIT_C || (full && bus.alu_valid))
                stall_q <= 1'b1;
            if (bus.alu_valid && stall_q)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            unique case (src)
                WB_ALU: begin
                    we_q <= (bus.alu_rd != '0);
                    if (bus.alu_rd != '0) begin
                        rd_q   <= bus.alu_rd;
                        data_q <= bus.alu_data;
                    end
                end
                WB_SLOW: begin
                    we_q   <= 1'b1;
                    rd_q   <= head.rd;
                    data_q <= head.data;
                end
                WB_NONE: we_q <= 1'b0;
                default: we_q <= 1'b0;
            endcase
        end
    end

    // slow_ready is forced low while reset is held
    assign bus.slow_ready = ready_q & ~rst;
    assign bus.wb_we      = we_q;
    assign bus.wb_rd      = rd_q;
    assign bus.wb_data    = data_q;
    assign bus.stall_req  = stall_q;
    assign bus.fifo_count = count;
    assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench: directed scenarios then random traffic, each cycle
// checked against a queue-based model of the writeback rules.
module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cnt;
        bit          rdy;
        bit          stall;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    ent_t        mq[$];
    int          m_starve = 0;
    bit          m_stall  = 0;
    bit          m_err    = 0;
    bit          m_we     = 0;
    logic [4:0]  m_rd     = '0;
    logic [31:0] m_data   = '0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push the expected post-edge state.
    task automatic cycle(input bit r, input bit av, input logic [4:0] ard,
                         input logic [31:0] ad, input bit sv,
                         input logic [4:0] srd, input logic [31:0] sd);
        exp_t e;
        ent_t h;
        bit   had;
        bit   wasfull;
        bit   acc;
        bit   popped;
        @(negedge clk);
        #1;
        rst            = r;
        bus.alu_valid  = av;
        bus.alu_rd     = ard;
        bus.alu_data   = ad;
        bus.slow_valid = sv;
        bus.slow_rd    = srd;
        bus.slow_data  = sd;
        if (r) begin
            mq.delete();
            m_starve = 0;
            m_stall  = 0;
            m_err    = 0;
            m_we     = 0;
            m_rd     = '0;
            m_data   = '0;
        end else begin
            had     = (mq.size() > 0);
            wasfull = (mq.size() == DEPTH);
            acc     = sv && (mq.size() < DEPTH);
            popped  = 0;
            if (av && m_stall) m_err = 1;
            if (av) begin
                m_we = (ard != 0);
                if (ard != 0) begin
                    m_rd   = ard;
                    m_data = ad;
                end
            end else if (had) begin
                h      = mq.pop_front();
                m_we   = 1;
                m_rd   = h.rd;
                m_data = h.data;
                popped = 1;
            end else begin
                m_we = 0;
            end
            if (acc && srd != 0) mq.push_back('{rd: srd, data: sd});
            if (popped || !had)  m_starve = 0;
            else if (av && m_starve < LIMIT) m_starve++;
            if (popped) m_stall = 0;
            else if (m_starve == LIMIT || (wasfull && av)) m_stall = 1;
        end
        e.we    = m_we;
        e.rd    = m_rd;
        e.data  = m_data;
        e.cnt   = mq.size();
        e.rdy   = !r && (mq.size() < DEPTH);
        e.stall = m_stall;
        e.err   = m_err;
        sb.push_back(e);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        cycle(0, 1, rd, d, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wb_we",      32'(bus.wb_we),      32'(e.we));
                chk("wb_rd",      32'(bus.wb_rd),      32'(e.rd));
                chk("wb_data",    bus.wb_data,         e.data);
                chk("fifo_count", 32'(bus.fifo_count), 32'(e.cnt));
                chk("slow_ready", 32'(bus.slow_ready), 32'(e.rdy));
                chk("stall_req",  32'(bus.stall_req),  32'(e.stall));
                chk("err_sticky", 32'(bus.err_sticky), 32'(e.err));
            end
        end
    end

    initial begin : stim
        bit av;
        bus.alu_valid  = 0;
        bus.alu_rd     = '0;
        bus.alu_data   = '0;
        bus.slow_valid = 0;
        bus.slow_rd    = '0;
        bus.slow_data  = '0;
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle();
        // ALU path, including rd==0
        alu(5, 32'hDEADBEEF);
        alu(0, 32'h00001234);
        idle();
        // slow path into an empty FIFO
        cycle(0, 0, 0, 0, 1, 7, 32'h12);
        idle();
        idle();
        // fill under ALU pressure, then drain in order
        cycle(0, 1, 1, 32'hA1, 1, 3, 32'hAA);
        cycle(0, 1, 2, 32'hA2, 1, 4, 32'hBB);
        alu(6, 32'hA3);
        idle();
        idle();
        idle();
        // starvation
        cycle(0, 0, 0, 0, 1, 9, 32'h99);
        for (int i = 0; i < LIMIT; i++) alu(5'(8 + i), 32'(i));
        idle();
        idle();
        // violation while stalled
        cycle(0, 0, 0, 0, 1, 10, 32'h10);
        for (int i = 0; i < LIMIT; i++) alu(5'(12 + i), 32'(i));
        alu(20, 32'hE0E0E0E0);
        idle();
        idle();
        // push and pop in one cycle with one entry queued
        cycle(0, 0, 0, 0, 1, 11, 32'h11);
        cycle(0, 0, 0, 0, 1, 12, 32'h12);
        idle();
        idle();
        // reset with a full FIFO
        cycle(0, 1, 1, 32'h1, 1, 13, 32'h13);
        cycle(0, 1, 2, 32'h2, 1, 14, 32'h14);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        // random traffic; upstream mostly honours stall_req
        for (int i = 0; i < 600; i++) begin
            if (m_stall) av = ($urandom_range(0, 15) == 0);
            else         av = ($urandom_range(0, 9) < 6);
            cycle(($urandom_range(0, 99) == 0), av,
                  5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 31)), $urandom);
        end
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
